// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads and
// buffers returned words in a small in-order queue whose head feeds the IF/ID register.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        Request_Alt_PC,
    input  logic [31:0] Alt_PC,
    output logic        Instr_Mem_Req,
    output logic [31:0] Instr_Mem_Addr,
    input  logic        Instr_Mem_Ack,
    input  logic [31:0] Instr_Mem_Data,
    output logic        Instr_Valid_IF,
    output logic [31:0] Instr1_IF,
    output logic [31:0] Instr_PC_IF,
    output logic [31:0] Instr_PC_Plus4_IF
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]       instr_mem [QDEPTH];
    logic [31:0]       pc_mem    [QDEPTH];
    logic [31:0]       pc4_mem   [QDEPTH];

    logic              flush, push, pop, room, valid;
    logic [31:0]       addr_plus4;
    logic              unused_alt_lsbs;

    assign unused_alt_lsbs = ^Alt_PC[1:0];
    assign addr_plus4      = addr_q + 32'd4;
    assign valid           = (count_q != '0);

    // A redirect outranks every other event: no push, no pop, queue flushed.
    assign flush = Request_Alt_PC;
    assign push  = (state_q == StWait) && Instr_Mem_Ack && !Request_Alt_PC;
    assign pop   = valid && !STALL && !Request_Alt_PC;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    assign room = (32'(count_d) < QDEPTH);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        if (Request_Alt_PC) begin
            fetch_pc_d = {Alt_PC[31:2], 2'b00};
            req_d      = 1'b0;
            unique case (state_q)
                StWait:    state_d = Instr_Mem_Ack ? StIdle : StDiscard;
                // A stale Ack landing with the redirect still retires the old request.
                StDiscard: state_d = Instr_Mem_Ack ? StIdle : StDiscard;
                default:   state_d = StIdle;
            endcase
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (room) begin
                        req_d   = 1'b1;
                        addr_d  = fetch_pc_q;
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (Instr_Mem_Ack) begin
                        fetch_pc_d = addr_plus4;
                        if (room) begin
                            addr_d = addr_plus4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end
                StDiscard: begin
                    if (Instr_Mem_Ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            addr_q     <= '0;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
            end
        end
    end

    // Queue storage needs no reset: the outputs are gated by the count.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= Instr_Mem_Data;
            pc_mem[wr_ptr_q]    <= addr_q;
            pc4_mem[wr_ptr_q]   <= addr_plus4;
        end
    end

    assign Instr_Mem_Req     = req_q;
    assign Instr_Mem_Addr    = addr_q;
    assign Instr_Valid_IF    = valid;
    assign Instr1_IF         = valid ? instr_mem[rd_ptr_q] : 32'd0;
    assign Instr_PC_IF       = valid ? pc_mem[rd_ptr_q]    : 32'd0;
    assign Instr_PC_Plus4_IF = valid ? pc4_mem[rd_ptr_q]   : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a queue-level reference model checked every cycle, a
// latency-programmable memory, and directed scenarios with literal expectations.
module tb_instr_fetch_unit;

    localparam int unsigned QDEPTH = 2;
    localparam logic [31:0] SALT   = 32'hA5A5A5A5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        Request_Alt_PC = 1'b0;
    logic [31:0] Alt_PC = 32'd0;
    logic        Instr_Mem_Req;
    logic [31:0] Instr_Mem_Addr;
    logic        Instr_Mem_Ack;
    logic [31:0] Instr_Mem_Data;
    logic        Instr_Valid_IF;
    logic [31:0] Instr1_IF, Instr_PC_IF, Instr_PC_Plus4_IF;

    logic        ack_auto = 1'b0;
    logic        ack_force = 1'b0;
    logic [31:0] mem_data = 32'd0;
    int          mem_lat = 1;

    assign Instr_Mem_Ack  = ack_auto | ack_force;
    assign Instr_Mem_Data = ack_force ? 32'hDEADBEEF : mem_data;

    // Second instance exercising address wrap; its memory answers every cycle (L=1).
    logic        rst_w = 1'b0;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'd0;
    logic        req_w, valid_w;
    logic [31:0] addr_w, instr_w, pc_w, pc4_w;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    bit          m_req, m_stale;
    logic [31:0] m_addr, m_fpc;

    instr_fetch_unit #(.RESET_PC(32'hBFC00000), .QDEPTH(QDEPTH)) u_dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .STALL             (STALL),
        .Request_Alt_PC    (Request_Alt_PC),
        .Alt_PC            (Alt_PC),
        .Instr_Mem_Req     (Instr_Mem_Req),
        .Instr_Mem_Addr    (Instr_Mem_Addr),
        .Instr_Mem_Ack     (Instr_Mem_Ack),
        .Instr_Mem_Data    (Instr_Mem_Data),
        .Instr_Valid_IF    (Instr_Valid_IF),
        .Instr1_IF         (Instr1_IF),
        .Instr_PC_IF       (Instr_PC_IF),
        .Instr_PC_Plus4_IF (Instr_PC_Plus4_IF)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFFFFF8), .QDEPTH(QDEPTH)) u_wrap (
        .CLK               (CLK),
        .RESET             (rst_w),
        .STALL             (zero_bit),
        .Request_Alt_PC    (zero_bit),
        .Alt_PC            (zero_word),
        .Instr_Mem_Req     (req_w),
        .Instr_Mem_Addr    (addr_w),
        .Instr_Mem_Ack     (req_w),
        .Instr_Mem_Data    (addr_w ^ SALT),
        .Instr_Valid_IF    (valid_w),
        .Instr1_IF         (instr_w),
        .Instr_PC_IF       (pc_w),
        .Instr_PC_Plus4_IF (pc4_w)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_addr  = 32'd0;
        m_fpc   = 32'hBFC00000;
    endtask

    task automatic model_step();
        bit     ack, pop, push, room;
        entry_t e;
        ack = (Instr_Mem_Ack === 1'b1);
        pop = (mq.size() > 0) && !STALL;
        if (Request_Alt_PC) begin
            mq.delete();
            m_fpc = {Alt_PC[31:2], 2'b00};
            if (m_req && !ack) m_stale = 1'b1;
            else if (m_stale && ack) m_stale = 1'b0;
            m_req = 1'b0;
        end else if (m_stale) begin
            if (ack) m_stale = 1'b0;
        end else begin
            push = m_req && ack;
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.instr = Instr_Mem_Data;
                e.pc    = m_addr;
                mq.push_back(e);
                m_fpc = m_addr + 32'd4;
            end
            room = (mq.size() < QDEPTH);
            if (m_req) begin
                if (push) begin
                    if (room) m_addr = m_addr + 32'd4;
                    else m_req = 1'b0;
                end
            end else if (room) begin
                m_req  = 1'b1;
                m_addr = m_fpc;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RESET);
            if (!RESET) model_reset();
            else model_step();
        end
    end

    // Memory: answers a request mem_lat cycles after it is first seen, data = addr ^ SALT.
    initial begin
        bit          busy;
        int          cnt;
        logic [31:0] cur;
        busy = 1'b0;
        cnt  = 0;
        cur  = 32'd0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RESET) begin
                busy     = 1'b0;
                ack_auto = 1'b0;
            end else begin
                if (ack_auto) begin
                    ack_auto = 1'b0;
                    busy     = 1'b0;
                end
                if (!busy && Instr_Mem_Req) begin
                    busy = 1'b1;
                    cnt  = mem_lat;
                    cur  = Instr_Mem_Addr;
                end
                if (busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        ack_auto = 1'b1;
                        mem_data = cur ^ SALT;
                    end
                end
            end
        end
    end

    initial begin
        bit          v;
        logic [31:0] hpc;
        forever begin
            @(negedge CLK);
            v   = (mq.size() > 0);
            hpc = v ? mq[0].pc : 32'd0;
            check("cyc_req",   Instr_Mem_Req,     m_req);
            check("cyc_addr",  Instr_Mem_Addr,    m_addr);
            check("cyc_valid", Instr_Valid_IF,    v);
            check("cyc_instr", Instr1_IF,         v ? mq[0].instr : 32'd0);
            check("cyc_pc",    Instr_PC_IF,       hpc);
            check("cyc_pc4",   Instr_PC_Plus4_IF, v ? hpc + 32'd4 : 32'd0);
        end
    end

    initial begin
        int          n;
        logic [31:0] frozen_pc;

        // Reset state and first fetches.
        repeat (2) @(negedge CLK);
        check("rst_req", Instr_Mem_Req, 1'b0);
        check("rst_addr", Instr_Mem_Addr, 32'd0);
        check("rst_valid", Instr_Valid_IF, 1'b0);
        check("rst_pc", Instr_PC_IF, 32'd0);
        RESET = 1'b1;
        @(negedge CLK);
        check("first_req", Instr_Mem_Req, 1'b1);
        check("first_addr", Instr_Mem_Addr, 32'hBFC00000);
        check("first_valid", Instr_Valid_IF, 1'b0);
        @(negedge CLK);
        check("seq_pc0", Instr_PC_IF, 32'hBFC00000);
        check("seq_instr0", Instr1_IF, 32'h1A65A5A5);
        check("seq_pc4_0", Instr_PC_Plus4_IF, 32'hBFC00004);
        @(negedge CLK);
        check("seq_pc1", Instr_PC_IF, 32'hBFC00004);
        @(negedge CLK);
        check("seq_pc2", Instr_PC_IF, 32'hBFC00008);
        check("seq_pc4_2", Instr_PC_Plus4_IF, 32'hBFC0000C);

        // Sustained stall fills the queue and parks the requester.
        STALL = 1'b1;
        frozen_pc = mq[0].pc;
        repeat (5) @(negedge CLK);
        check("stall_req", Instr_Mem_Req, 1'b0);
        check("stall_valid", Instr_Valid_IF, 1'b1);
        check("stall_pc", Instr_PC_IF, frozen_pc);
        check("stall_model_full", mq.size(), 2);
        STALL = 1'b0;
        @(negedge CLK);
        check("unstall_req", Instr_Mem_Req, 1'b1);
        check("unstall_addr", Instr_Mem_Addr, frozen_pc + 32'd8);
        repeat (3) @(negedge CLK);

        // Redirect while a long-latency request is outstanding.
        mem_lat = 4;
        n = 0;
        while (!(Instr_Mem_Req && !Instr_Mem_Ack) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout_fail("wait_busy");
        Request_Alt_PC = 1'b1;
        Alt_PC = 32'h00400103;
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        check("disc_req", Instr_Mem_Req, 1'b0);
        check("disc_valid", Instr_Valid_IF, 1'b0);
        check("disc_instr", Instr1_IF, 32'd0);
        check("disc_pc", Instr_PC_IF, 32'd0);
        n = 0;
        while (!Instr_Mem_Req && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout_fail("wait_redirect_req");
        check("redir_addr", Instr_Mem_Addr, 32'h00400100);
        check("redir_valid", Instr_Valid_IF, 1'b0);

        // Redirect landing in the same cycle as an Ack.
        n = 0;
        while (!(Instr_Mem_Req && Instr_Mem_Ack) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout_fail("wait_ack");
        Request_Alt_PC = 1'b1;
        Alt_PC = 32'h00400203;
        @(negedge CLK);
        Request_Alt_PC = 1'b0;
        check("coinc_req", Instr_Mem_Req, 1'b0);
        check("coinc_valid", Instr_Valid_IF, 1'b0);
        @(negedge CLK);
        check("coinc_req2", Instr_Mem_Req, 1'b1);
        check("coinc_addr", Instr_Mem_Addr, 32'h00400200);

        // Asynchronous reset with one entry queued and a request in flight.
        STALL = 1'b1;
        mem_lat = 3;
        n = 0;
        while (!(Instr_Valid_IF && Instr_Mem_Req) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) timeout_fail("wait_one_queued");
        check("mid_model_q1", mq.size(), 1);
        #2;
        RESET = 1'b0;
        #1;
        check("mid_req", Instr_Mem_Req, 1'b0);
        check("mid_addr", Instr_Mem_Addr, 32'd0);
        check("mid_valid", Instr_Valid_IF, 1'b0);
        check("mid_instr", Instr1_IF, 32'd0);
        check("mid_pc", Instr_PC_IF, 32'd0);
        check("mid_pc4", Instr_PC_Plus4_IF, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        STALL = 1'b0;
        mem_lat = 1;
        ack_force = 1'b1;
        @(posedge CLK);
        #1;
        ack_force = 1'b0;
        @(negedge CLK);
        check("post_req", Instr_Mem_Req, 1'b1);
        check("post_addr", Instr_Mem_Addr, 32'hBFC00000);
        check("post_valid", Instr_Valid_IF, 1'b0);
        @(negedge CLK);
        check("post_pc", Instr_PC_IF, 32'hBFC00000);
        check("post_instr", Instr1_IF, 32'h1A65A5A5);

        // Address wrap on the second instance.
        rst_w = 1'b1;
        @(negedge CLK);
        check("wrap_req", req_w, 1'b1);
        check("wrap_addr", addr_w, 32'hFFFFFFF8);
        @(negedge CLK);
        check("wrap_pc0", pc_w, 32'hFFFFFFF8);
        check("wrap_instr0", instr_w, 32'h5A5A5A5D);
        check("wrap_pc4_0", pc4_w, 32'hFFFFFFFC);
        @(negedge CLK);
        check("wrap_pc1", pc_w, 32'hFFFFFFFC);
        check("wrap_pc4_1", pc4_w, 32'h00000000);
        @(negedge CLK);
        check("wrap_pc2", pc_w, 32'h00000000);
        check("wrap_pc4_2", pc4_w, 32'h00000004);
        check("wrap_valid", valid_w, 1'b1);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
